// File: rtl/fpa_align_ctrl.sv
// FP adder alignment front end: unpack, magnitude-order, drive the right shifter
// and carry the larger operand in a latency-matched sideband. Option: ALIGN_STICKY_EN.
module fpa_align_ctrl #(
  parameter int SHIFT_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] shf_x,
  output logic [4:0]  shf_s,
  output logic        shf_valid,
  output logic        al_valid,
  output logic [23:0] al_mant_l,
  output logic [7:0]  al_exp,
  output logic        al_sign,
  output logic        al_sub,
  output logic        al_sticky
);

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic        hid;
    logic [22:0] frac;
  } opnd_t;

  typedef struct packed {
    logic [23:0] mant;
    logic [7:0]  exp;
    logic        sign;
    logic        sub;
`ifdef ALIGN_STICKY_EN
    logic        sticky;
`endif
  } sb_t;

  // Denormals take effective exponent 1 with hidden bit 0.
  function automatic opnd_t unpack(input logic [31:0] f);
    opnd_t o;
    o.sign = f[31];
    o.hid  = |f[30:23];
    o.exp  = o.hid ? f[30:23] : 8'd1;
    o.frac = f[22:0];
    return o;
  endfunction

  // Stage U
  opnd_t ua_q, ub_q;
  logic  u_vld_q, u_age_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ua_q    <= '0;
      ub_q    <= '0;
      u_vld_q <= 1'b0;
      u_age_q <= 1'b0;
    end else begin
      ua_q    <= unpack(in_a);
      ub_q    <= unpack(in_b);
      u_vld_q <= in_valid;
      u_age_q <= (in_a[30:0] >= in_b[30:0]);
    end
  end

  // Stage S combinational: swap, difference, shifter operands
  opnd_t       op_l, op_s;
  logic [7:0]  diff;
  logic        far;
  logic [31:0] shf_x_d;
  logic [4:0]  shf_s_d;
  sb_t         sb_d;

  always_comb begin
    op_l    = u_age_q ? ua_q : ub_q;
    op_s    = u_age_q ? ub_q : ua_q;
    diff    = op_l.exp - op_s.exp;
    far     = (diff > 8'd31);
    shf_x_d = far ? 32'd0 : {op_s.hid, op_s.frac, 8'd0};
    shf_s_d = far ? 5'd0  : diff[4:0];
    sb_d      = '0;
    sb_d.mant = {op_l.hid, op_l.frac};
    sb_d.exp  = op_l.exp;
    sb_d.sign = op_l.sign;
    sb_d.sub  = ua_q.sign ^ ub_q.sign;
`ifdef ALIGN_STICKY_EN
    // Mask of the bits the shifter drops; empty when the shift is zero.
    sb_d.sticky = far ? |{op_s.hid, op_s.frac}
                      : |(shf_x_d & ((32'd1 << shf_s_d) - 32'd1));
`endif
  end

  // Stage S register followed by SHIFT_LAT sideband stages
  logic [31:0]        shf_x_q;
  logic [4:0]         shf_s_q;
  logic [SHIFT_LAT:0] vld_pipe_q;
  sb_t                sb_q [SHIFT_LAT+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shf_x_q    <= '0;
      shf_s_q    <= '0;
      vld_pipe_q <= '0;
      for (int i = 0; i <= SHIFT_LAT; i++) sb_q[i] <= '0;
    end else begin
      shf_x_q    <= shf_x_d;
      shf_s_q    <= shf_s_d;
      vld_pipe_q <= {vld_pipe_q[SHIFT_LAT-1:0], u_vld_q};
      sb_q[0]    <= sb_d;
      for (int i = 1; i <= SHIFT_LAT; i++) sb_q[i] <= sb_q[i-1];
    end
  end

  assign shf_x     = shf_x_q;
  assign shf_s     = shf_s_q;
  assign shf_valid = vld_pipe_q[0];
  assign al_valid  = vld_pipe_q[SHIFT_LAT];
  assign al_mant_l = sb_q[SHIFT_LAT].mant;
  assign al_exp    = sb_q[SHIFT_LAT].exp;
  assign al_sign   = sb_q[SHIFT_LAT].sign;
  assign al_sub    = sb_q[SHIFT_LAT].sub;
`ifdef ALIGN_STICKY_EN
  assign al_sticky = sb_q[SHIFT_LAT].sticky;
`else
  assign al_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_fpa_align_ctrl.sv
// Directed bench for fpa_align_ctrl: hand-computed vectors, back-to-back stream
// with a bubble, and asynchronous reset with operands in flight.
module tb_fpa_align_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_a, in_b;
  logic [31:0] shf_x;
  logic [4:0]  shf_s;
  logic        shf_valid, al_valid;
  logic [23:0] al_mant_l;
  logic [7:0]  al_exp;
  logic        al_sign, al_sub, al_sticky;

  fpa_align_ctrl #(.SHIFT_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .shf_x(shf_x), .shf_s(shf_s), .shf_valid(shf_valid),
    .al_valid(al_valid), .al_mant_l(al_mant_l), .al_exp(al_exp),
    .al_sign(al_sign), .al_sub(al_sub), .al_sticky(al_sticky)
  );

  always #5 clk = ~clk;

`ifdef ALIGN_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  typedef struct {
    logic        v;
    logic [31:0] a, b, x;
    logic [4:0]  s;
    logic [23:0] m;
    logic [7:0]  e;
    logic        sg, sb, st;
  } vec_t;

  localparam int N = 13;
  vec_t vt [N];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [31:0] a, b, x, input logic [4:0] s,
                              input logic [23:0] m, input logic [7:0] e,
                              input logic sg, sb, st);
    vec_t t;
    t.v = v; t.a = a; t.b = b; t.x = x; t.s = s; t.m = m; t.e = e;
    t.sg = sg; t.sb = sb; t.st = st & STK;
    return t;
  endfunction

  task automatic drive(input logic v, input logic [31:0] a, b);
    in_valid = v; in_a = a; in_b = b;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_shf_x"}, shf_x, 32'd0);
    chk({tag, "_shf_s"}, {27'd0, shf_s}, 32'd0);
    chk({tag, "_shf_v"}, {31'd0, shf_valid}, 32'd0);
    chk({tag, "_al_v"}, {31'd0, al_valid}, 32'd0);
    chk({tag, "_al_m"}, {8'd0, al_mant_l}, 32'd0);
    chk({tag, "_al_e"}, {24'd0, al_exp}, 32'd0);
    chk({tag, "_al_flags"}, {29'd0, al_sign, al_sub, al_sticky}, 32'd0);
  endtask

  task automatic chk_shf(input int idx);
    if (idx >= 0 && idx < N && vt[idx].v) begin
      chk($sformatf("shf_v[%0d]", idx), {31'd0, shf_valid}, 32'd1);
      chk($sformatf("shf_x[%0d]", idx), shf_x, vt[idx].x);
      chk($sformatf("shf_s[%0d]", idx), {27'd0, shf_s}, {27'd0, vt[idx].s});
    end else begin
      chk($sformatf("shf_bubble[%0d]", idx), {31'd0, shf_valid}, 32'd0);
    end
  endtask

  task automatic chk_al(input int idx);
    if (idx >= 0 && idx < N && vt[idx].v) begin
      chk($sformatf("al_v[%0d]", idx), {31'd0, al_valid}, 32'd1);
      chk($sformatf("al_m[%0d]", idx), {8'd0, al_mant_l}, {8'd0, vt[idx].m});
      chk($sformatf("al_e[%0d]", idx), {24'd0, al_exp}, {24'd0, vt[idx].e});
      chk($sformatf("al_sign[%0d]", idx), {31'd0, al_sign}, {31'd0, vt[idx].sg});
      chk($sformatf("al_sub[%0d]", idx), {31'd0, al_sub}, {31'd0, vt[idx].sb});
      chk($sformatf("al_stk[%0d]", idx), {31'd0, al_sticky}, {31'd0, vt[idx].st});
    end else begin
      chk($sformatf("al_bubble[%0d]", idx), {31'd0, al_valid}, 32'd0);
    end
  endtask

  initial begin
    //          v     a             b             shf_x         s   mant       exp    sg    sb    st
    vt[0]  = mk(1'b1, 32'h40400000, 32'h3F800000, 32'h80000000, 1,  24'hC00000, 8'h80, 1'b0, 1'b0, 1'b0);
    vt[1]  = mk(1'b1, 32'hBF800000, 32'h40400000, 32'h80000000, 1,  24'hC00000, 8'h80, 1'b0, 1'b1, 1'b0);
    vt[2]  = mk(1'b1, 32'h50000000, 32'h3F800001, 32'h00000000, 0,  24'h800000, 8'hA0, 1'b0, 1'b0, 1'b1);
    vt[3]  = mk(1'b1, 32'h4C000000, 32'h3F800001, 32'h80000100, 25, 24'h800000, 8'h98, 1'b0, 1'b0, 1'b1);
    vt[4]  = mk(1'b1, 32'h00800000, 32'h00000001, 32'h00000100, 0,  24'h800000, 8'h01, 1'b0, 1'b0, 1'b0);
    vt[5]  = mk(1'b1, 32'h3F800000, 32'h3F800000, 32'h80000000, 0,  24'h800000, 8'h7F, 1'b0, 1'b0, 1'b0);
    vt[6]  = mk(1'b0, 32'h12345678, 32'h9ABCDEF0, 32'h0,        0,  24'h0,      8'h00, 1'b0, 1'b0, 1'b0);
    vt[7]  = mk(1'b1, 32'hC0000000, 32'h3F000000, 32'h80000000, 2,  24'h800000, 8'h80, 1'b1, 1'b1, 1'b0);
    vt[8]  = mk(1'b1, 32'h3FC00000, 32'hBFA00000, 32'hA0000000, 0,  24'hC00000, 8'h7F, 1'b0, 1'b1, 1'b0);
    vt[9]  = mk(1'b1, 32'h00000003, 32'h00000005, 32'h00000300, 0,  24'h000005, 8'h01, 1'b0, 1'b0, 1'b0);
    vt[10] = mk(1'b1, 32'h7F800000, 32'h00000001, 32'h00000000, 0,  24'h800000, 8'hFF, 1'b0, 1'b0, 1'b1);
    vt[11] = mk(1'b1, 32'h4F000000, 32'h3F800000, 32'h80000000, 31, 24'h800000, 8'h9E, 1'b0, 1'b0, 1'b0);
    vt[12] = mk(1'b1, 32'h4F000000, 32'h3F800080, 32'h80008000, 31, 24'h800000, 8'h9E, 1'b0, 1'b0, 1'b1);

    rst_n = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    #1;
    chk_zero("reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous stream: slot c enters at c, shifter side at c+2, sideband at c+6.
    for (int c = 0; c < N + 7; c++) begin
      @(posedge clk); #1;
      if (c < N) drive(vt[c].v, vt[c].a, vt[c].b);
      else       drive(1'b0, 32'd0, 32'd0);
      @(negedge clk);
      chk_shf(c - 2);
      chk_al(c - 6);
    end

    // Three operands in flight, then asynchronous reset mid-cycle.
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (c < 3) drive(1'b1, vt[c].a, vt[c].b);
      else       drive(1'b0, 32'd0, 32'd0);
    end
    chk("pre_rst_shf_v", {31'd0, shf_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    #3 rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("post_rst_shf_v", {31'd0, shf_valid}, 32'd0);
      chk("post_rst_al_v", {31'd0, al_valid}, 32'd0);
    end

    // Fresh operand after reset: shifter at +2, sideband at +6.
    @(posedge clk); #1;
    drive(1'b1, vt[3].a, vt[3].b);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      drive(1'b0, 32'd0, 32'd0);
      @(negedge clk);
      chk($sformatf("relat_shf_v%0d", k), {31'd0, shf_valid}, {31'd0, k == 2});
      chk($sformatf("relat_al_v%0d", k), {31'd0, al_valid}, {31'd0, k == 6});
      if (k == 6) begin
        chk("relat_al_e", {24'd0, al_exp}, 32'h98);
        chk("relat_al_stk", {31'd0, al_sticky}, {31'd0, STK});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
